gb_iodec: RTL and testbench
===========================

GB_IODEC -- requirements
Module: gb_iodec

Interface
REQ-001 SHALL have parameter NCH, default 9: number of decoded channels, range 1..16.
REQ-002 SHALL have parameter DATA_W, default 8: data width.
REQ-003 SHALL have parameter BASE, default the iomap package table: NCH*8-bit packed channel base addresses.
REQ-004 SHALL have parameter MASK, default the iomap package table: NCH*8-bit packed compare masks, where 1 means the bit is compared.
REQ-005 SHALL have parameter BROM_CH, default 6: channel index of the boot-ROM hide register.
REQ-006 SHALL have port clk  in  1  sole clock; all state on the rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-008 SHALL have port adr  in  8  low address byte of the 0xff00-0xffff window.
REQ-009 SHALL have port cs  in  1  IO window access strobe, held for the whole access.
REQ-010 SHALL have port rd  in  1  read request, qualified by cs.
REQ-011 SHALL have port wr  in  1  write request, qualified by cs.
REQ-012 SHALL have port din  in  DATA_W  write data.
REQ-013 SHALL have port rdata_ch  in  NCH*DATA_W  per-channel read data; channel i at bits [i*DATA_W +: DATA_W].
REQ-014 SHALL have port sel  out  NCH  registered one-hot channel select.
REQ-015 SHALL have port dout  out  DATA_W  registered read data.
REQ-016 SHALL have port ack  out  1  single-cycle access-complete pulse.
REQ-017 SHALL have port brom_hidden  out  1  sticky boot-ROM-hidden flag.

Function
REQ-018 SHALL decode channel i as a match when (adr & MASK[i]) == (BASE[i] & MASK[i]); the lowest matching index wins.
REQ-019 SHALL use a 3-state FSM: IDLE, SEL, DONE.
- IDLE: on cs & (rd|wr), latch adr and the rd/wr type, register sel, go to SEL; sel is visible 1 cycle after the cs edge.
- SEL, write: pulse ack, go to DONE.
- SEL, read: register dout from the selected channel (0xff if no channel matched), go to DONE.
- DONE, read: pulse ack this cycle.
- Write ack latency: 1 cycle after the sampled edge. Read ack latency: 2 cycles.
REQ-020 SHALL hold sel and dout in DONE while cs=1, and return to IDLE with sel=0 the cycle after cs=0.
REQ-021 SHALL ignore adr, rd and wr changes while not in IDLE; the latched values govern the access.
REQ-022 SHALL treat rd&wr both high as a write; dout SHALL stay unchanged.
REQ-023 SHALL abort to IDLE on cs=0 in SEL: sel cleared next cycle, no ack, dout unchanged.
REQ-024 SHALL keep ack=0 and sel=0 in IDLE.
REQ-025 SHALL set brom_hidden when a write to BROM_CH with din[0]=1 reaches SEL; it SHALL stay set until reset, and later writes have no effect.
REQ-026 SHALL return {DATA_W-1 ones, brom_hidden} on reads of BROM_CH instead of rdata_ch.
REQ-027 SHALL accept a new access in the cycle after returning to IDLE; a back-to-back access needs cs low for at least 1 cycle.

Reset
REQ-028 SHALL, on reset=0 at a clock edge, force state=IDLE, sel=0, dout=0xff, ack=0, brom_hidden=0, abandoning any access in flight without ack.
REQ-029 SHALL ignore cs, rd and wr while reset=0.

Configuration
REQ-030 SHALL, with GB_IODEC_BUSERR_EN defined, add output buserr_cnt (8 bits): increments once per unmapped access reaching SEL, saturates at 0xff, resets to 0, and is readable as channel NCH at adr 0x7f ahead of the normal decode.
REQ-031 SHALL, without GB_IODEC_BUSERR_EN, have no buserr_cnt port or counter, and 0x7f decodes normally.

Structure
REQ-032 SHALL take from package gb_iomap_pkg: default BASE/MASK tables, channel index constants (P1, SER, TIM, IF, SND, PPU, BROM, HRAM, IE), FSM state typedef, and UNMAPPED_DATA = 0xff.
REQ-033 SHALL place the combinational priority match in one sub-module, gb_iodec_match (adr, BASE, MASK to one-hot plus hit); the FSM and registers stay in gb_iodec.

Verification
REQ-034 Read 0xff0f with rdata_ch[IF]=0xe1 -> sel=1<<IF at +1, dout=0xe1 and ack at +2.
REQ-035 Write 0xff50 with din=0x01, then read 0xff50 -> brom_hidden=1 from +2; read gives dout=0xff; write 0x00 leaves it 1.
REQ-036 Read 0xff4c (unmapped) -> sel=0, dout=0xff at +2; with GB_IODEC_BUSERR_EN, buserr_cnt increments by 1; 300 such reads -> 0xff.
REQ-037 Read 0xff80 while adr changes to 0xffff mid-access -> only the HRAM bit set; rd&wr both high -> write ack at +1, dout unchanged.
REQ-038 reset=0 in SEL -> no ack, sel=0 and dout=0xff next cycle; cs=0 in SEL -> no ack, sel cleared next cycle.

Source files
------------

// File: rtl/gb_iomap_pkg.sv
// Game Boy 0xff00-0xffff IO window map: channel indices, default decode tables,
// decoder FSM states and the value returned by unmapped reads.
package gb_iomap_pkg;

    localparam int IOMAP_NCH = 9;

    // Lowest index wins, so IE (0xff) sits below HRAM (0x80-0xff) and P1 below SER.
    localparam int P1   = 0;
    localparam int SER  = 1;
    localparam int TIM  = 2;
    localparam int IF   = 3;
    localparam int SND  = 4;
    localparam int PPU  = 5;
    localparam int BROM = 6;
    localparam int IE   = 7;
    localparam int HRAM = 8;

    // Packed tables, channel i at [i*8 +: 8]; listed from channel 8 down to channel 0.
    localparam logic [IOMAP_NCH*8-1:0] IOMAP_BASE = {
        8'h80, 8'hff, 8'h50, 8'h40, 8'h00, 8'h0f, 8'h04, 8'h00, 8'h00
    };
    localparam logic [IOMAP_NCH*8-1:0] IOMAP_MASK = {
        8'h80, 8'hff, 8'hff, 8'hf8, 8'hc0, 8'hff, 8'hfc, 8'hfc, 8'hff
    };

    localparam logic [7:0] UNMAPPED_DATA = 8'hff;
    localparam logic [7:0] BUSERR_ADR    = 8'h7f;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEL,
        ST_DONE
    } iodec_state_e;

endpackage

// File: rtl/gb_iodec_match.sv
// Combinational priority address match: one-hot of the lowest-index channel whose
// masked base equals the masked address, plus a hit flag.
module gb_iodec_match
    import gb_iomap_pkg::*;
#(
    parameter int                NCH  = IOMAP_NCH,
    parameter logic [NCH*8-1:0]  BASE = IOMAP_BASE,
    parameter logic [NCH*8-1:0]  MASK = IOMAP_MASK
) (
    input  logic [7:0]     adr_i,
    output logic [NCH-1:0] onehot_o,
    output logic           hit_o
);

    // NOTE: every output gets a default before the loop, otherwise the tool infers latches.
    always_comb begin
        onehot_o = '0;
        hit_o    = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if ((adr_i & MASK[i*8 +: 8]) == (BASE[i*8 +: 8] & MASK[i*8 +: 8])) begin
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                hit_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gb_iodec.sv
// IO window decoder: registered one-hot select, read mux, boot-ROM hide flag.
// Optional bus-error counter (readable at 0x7f) enabled by GB_IODEC_BUSERR_EN.
module gb_iodec
    import gb_iomap_pkg::*;
#(
    parameter int                NCH     = IOMAP_NCH,
    parameter int                DATA_W  = 8,
    parameter logic [NCH*8-1:0]  BASE    = IOMAP_BASE,
    parameter logic [NCH*8-1:0]  MASK    = IOMAP_MASK,
    parameter int                BROM_CH = BROM
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            adr,
    input  logic                  cs,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [DATA_W-1:0]     din,
    input  logic [NCH*DATA_W-1:0] rdata_ch,
    output logic [NCH-1:0]        sel,
    output logic [DATA_W-1:0]     dout,
    output logic                  ack,
`ifdef GB_IODEC_BUSERR_EN
    output logic [7:0]            buserr_cnt,
`endif
    output logic                  brom_hidden
);

    iodec_state_e      state_q;
    logic [NCH-1:0]    sel_q;
    logic [DATA_W-1:0] dout_q;
    logic              ack_q;
    logic              brom_q;
    logic              is_wr_q;
    logic              wbit_q;
    logic              hit_q;
    logic [NCH-1:0]    match_oh;
    logic              match_hit;
    logic [DATA_W-1:0] rd_mux_d;
    logic              unused_din;
`ifdef GB_IODEC_BUSERR_EN
    logic              errsel_q;
    logic [7:0]        cnt_q;
`endif

    gb_iodec_match #(
        .NCH  (NCH),
        .BASE (BASE),
        .MASK (MASK)
    ) u_match (
        .adr_i    (adr),
        .onehot_o (match_oh),
        .hit_o    (match_hit)
    );

    // Only din[0] carries meaning (the boot-ROM hide bit).
    assign unused_din = ^din;

    always_comb begin
        rd_mux_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel_q[i]) rd_mux_d = rd_mux_d | rdata_ch[i*DATA_W +: DATA_W];
        end
        if (!hit_q) rd_mux_d = DATA_W'(UNMAPPED_DATA);
        else if (sel_q[BROM_CH]) rd_mux_d = {{(DATA_W-1){1'b1}}, brom_q};
`ifdef GB_IODEC_BUSERR_EN
        if (errsel_q) rd_mux_d = DATA_W'(cnt_q);
`endif
    end

    // NOTE: state lives in always_ff with non-blocking assignments only, so every
    // register sees the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            dout_q  <= DATA_W'(UNMAPPED_DATA);
            ack_q   <= 1'b0;
            brom_q  <= 1'b0;
            is_wr_q <= 1'b0;
            wbit_q  <= 1'b0;
            hit_q   <= 1'b0;
`ifdef GB_IODEC_BUSERR_EN
            errsel_q <= 1'b0;
            cnt_q    <= 8'h00;
`endif
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cs && (rd || wr)) begin
                        state_q <= ST_SEL;
                        is_wr_q <= wr;
                        wbit_q  <= din[0];
`ifdef GB_IODEC_BUSERR_EN
                        if (adr == BUSERR_ADR) begin
                            sel_q    <= '0;
                            hit_q    <= 1'b1;
                            errsel_q <= 1'b1;
                        end else begin
                            sel_q    <= match_oh;
                            hit_q    <= match_hit;
                            errsel_q <= 1'b0;
                            if (!match_hit && cnt_q != 8'hff) cnt_q <= cnt_q + 8'd1;
                        end
`else
                        sel_q <= match_oh;
                        hit_q <= match_hit;
`endif
                    end
                end
                ST_SEL: begin
                    if (!cs) begin
                        state_q <= ST_IDLE;
                        sel_q   <= '0;
                    end else begin
                        state_q <= ST_DONE;
                        if (is_wr_q) begin
                            if (sel_q[BROM_CH] && wbit_q) brom_q <= 1'b1;
                        end else begin
                            dout_q <= rd_mux_d;
                            ack_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!cs) begin
                        state_q <= ST_IDLE;
                        sel_q   <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Write ack is the SEL cycle itself, withdrawn if the master drops cs to abort.
    assign ack         = ack_q | ((state_q == ST_SEL) && is_wr_q && cs);
    assign sel         = sel_q;
    assign dout        = dout_q;
    assign brom_hidden = brom_q;
`ifdef GB_IODEC_BUSERR_EN
    assign buserr_cnt  = cnt_q;
`endif

endmodule

// File: tb/tb_gb_iodec.sv
// Directed bench for gb_iodec: decode, read/write timing, boot-ROM flag, abort,
// reset and (with GB_IODEC_BUSERR_EN) the bus-error counter.
module tb_gb_iodec;

    localparam int NCH    = 9;
    localparam int DATA_W = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [7:0]            adr;
    logic                  cs, rd, wr;
    logic [DATA_W-1:0]     din;
    logic [NCH*DATA_W-1:0] rdata_ch;
    logic [NCH-1:0]        sel;
    logic [DATA_W-1:0]     dout;
    logic                  ack;
    logic                  brom_hidden;
`ifdef GB_IODEC_BUSERR_EN
    logic [7:0]            buserr_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    gb_iodec dut (
        .clk         (clk),
        .reset       (reset),
        .adr         (adr),
        .cs          (cs),
        .rd          (rd),
        .wr          (wr),
        .din         (din),
        .rdata_ch    (rdata_ch),
        .sel         (sel),
        .dout        (dout),
        .ack         (ack),
`ifdef GB_IODEC_BUSERR_EN
        .buserr_cnt  (buserr_cnt),
`endif
        .brom_hidden (brom_hidden)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input string tag, input logic [7:0] a,
                           input logic [NCH-1:0] esel, input logic [7:0] edout);
        adr = a; cs = 1'b1; rd = 1'b1; wr = 1'b0;
        step();
        check({tag, "_sel1"}, 32'(sel), 32'(esel));
        check({tag, "_ack1"}, 32'(ack), 32'd0);
        adr = 8'h33; rd = 1'b0;
        step();
        check({tag, "_dout2"}, 32'(dout), 32'(edout));
        check({tag, "_ack2"}, 32'(ack), 32'd1);
        check({tag, "_sel2"}, 32'(sel), 32'(esel));
        step();
        check({tag, "_ack3"}, 32'(ack), 32'd0);
        check({tag, "_hold"}, 32'(sel), 32'(esel));
        cs = 1'b0;
        step();
        check({tag, "_selclr"}, 32'(sel), 32'd0);
        check({tag, "_douthold"}, 32'(dout), 32'(edout));
    endtask

    task automatic do_write(input string tag, input logic [7:0] a, input logic [7:0] d,
                            input logic [NCH-1:0] esel);
        adr = a; din = d; cs = 1'b1; wr = 1'b1; rd = 1'b0;
        step();
        check({tag, "_ack1"}, 32'(ack), 32'd1);
        check({tag, "_sel1"}, 32'(sel), 32'(esel));
        step();
        check({tag, "_ack2"}, 32'(ack), 32'd0);
        cs = 1'b0; wr = 1'b0;
        step();
        check({tag, "_selclr"}, 32'(sel), 32'd0);
    endtask

    initial begin
        reset = 1'b0; adr = 8'h00; cs = 1'b0; rd = 1'b0; wr = 1'b0; din = 8'h00;
        for (int i = 0; i < NCH; i++) rdata_ch[i*DATA_W +: DATA_W] = 8'(8'ha0 + i);
        rdata_ch[3*DATA_W +: DATA_W] = 8'he1;
        step();
        step();
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_dout", 32'(dout), 32'hff);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_brom", 32'(brom_hidden), 32'd0);
        reset = 1'b1;
        step();

        // IF = channel 3, TIM = 2 (0x04-0x07), SER = 1, IE = 7, HRAM = 8, BROM = 6.
        do_read("rd_if",   8'h0f, 9'h008, 8'he1);
        do_read("rd_tim",  8'h05, 9'h004, 8'ha2);
        do_read("rd_unm",  8'h4c, 9'h000, 8'hff);
        do_read("rd_ser",  8'h01, 9'h002, 8'ha1);
        do_read("rd_ie",   8'hff, 9'h080, 8'ha7);
        do_read("rd_p1",   8'h00, 9'h001, 8'ha0);
        do_read("rd_brom0", 8'h50, 9'h040, 8'hfe);

        // HRAM read with address moving to 0xff mid-access: latched 0x80 governs.
        adr = 8'h80; cs = 1'b1; rd = 1'b1;
        step();
        check("hram_sel1", 32'(sel), 32'h100);
        adr = 8'hff;
        step();
        check("hram_dout", 32'(dout), 32'ha8);
        check("hram_sel2", 32'(sel), 32'h100);
        check("hram_ack", 32'(ack), 32'd1);
        cs = 1'b0; rd = 1'b0;
        step();

        // Boot-ROM hide: set by a write of 1, sticky against a later write of 0.
        adr = 8'h50; din = 8'h01; cs = 1'b1; wr = 1'b1;
        step();
        check("brom_ack1", 32'(ack), 32'd1);
        check("brom_flag1", 32'(brom_hidden), 32'd0);
        step();
        check("brom_flag2", 32'(brom_hidden), 32'd1);
        cs = 1'b0; wr = 1'b0;
        step();
        do_read("rd_brom1", 8'h50, 9'h040, 8'hff);
        do_write("wr_brom0", 8'h50, 8'h00, 9'h040);
        check("brom_sticky", 32'(brom_hidden), 32'd1);

        // rd and wr together act as a write: ack at +1, dout untouched.
        do_read("rd_tim2", 8'h05, 9'h004, 8'ha2);
        adr = 8'h0f; cs = 1'b1; rd = 1'b1; wr = 1'b1;
        step();
        check("rdwr_ack", 32'(ack), 32'd1);
        step();
        check("rdwr_ack2", 32'(ack), 32'd0);
        check("rdwr_dout", 32'(dout), 32'ha2);
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        step();

        // cs dropped in SEL aborts: no ack, sel cleared, dout unchanged.
        adr = 8'h0f; cs = 1'b1; rd = 1'b1;
        step();
        check("abort_sel1", 32'(sel), 32'h008);
        cs = 1'b0; rd = 1'b0;
        step();
        check("abort_sel2", 32'(sel), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_dout", 32'(dout), 32'ha2);
        step();
        check("abort_ack2", 32'(ack), 32'd0);

        // Reset while in SEL abandons the access; cs is ignored during reset.
        adr = 8'h05; cs = 1'b1; rd = 1'b1;
        step();
        check("rstsel_sel1", 32'(sel), 32'h004);
        reset = 1'b0;
        step();
        check("rstsel_ack", 32'(ack), 32'd0);
        check("rstsel_sel", 32'(sel), 32'd0);
        check("rstsel_dout", 32'(dout), 32'hff);
        check("rstsel_brom", 32'(brom_hidden), 32'd0);
        step();
        check("rstcs_sel", 32'(sel), 32'd0);
        check("rstcs_ack", 32'(ack), 32'd0);
        cs = 1'b0; rd = 1'b0; reset = 1'b1;
        step();
        check("rstrel_ack", 32'(ack), 32'd0);

`ifdef GB_IODEC_BUSERR_EN
        do_read("rd_cnt0", 8'h7f, 9'h000, 8'h00);
        do_read("rd_unm1", 8'h4c, 9'h000, 8'hff);
        check("cnt_one", 32'(buserr_cnt), 32'd1);
        for (int n = 0; n < 300; n++) begin
            adr = 8'h4c; cs = 1'b1; rd = 1'b1;
            step();
            step();
            cs = 1'b0; rd = 1'b0;
            step();
            step();
        end
        check("cnt_sat", 32'(buserr_cnt), 32'hff);
        do_read("rd_cntff", 8'h7f, 9'h000, 8'hff);
`else
        do_read("rd_7f", 8'h7f, 9'h000, 8'hff);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
